dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM-stage side of the pipelined RISC-V core.
- The EX/MEM pipeline register drives MemRead/MemWrite/address/store data into this block. The block holds the pipeline with a stall until the access completes, then returns load data with a one-cycle acknowledge.
- It replaces the single-cycle data memory so that realistic memory latency can be modelled.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; word index = addr_i[31:2].
- LATENCY, 4, cycles from request accept to ack_o; legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- MemRead_i  in  1  load request level; held by the pipeline while stalled.
- MemWrite_i  in  1  store request level; held by the pipeline while stalled.
- addr_i  in  32  byte address.
- data_i  in  32  store data.
- data_o  out  32  load data, registered.
- stall_o  out  1  freeze PC/IFID/IDEX/EXMEM/MEMWB this cycle.
- ack_o  out  1  one-cycle pulse: access completed this cycle.
- err_o  out  1  one-cycle pulse coincident with ack_o: access rejected.

Behaviour:
- Single clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE, counter 0, data_o 0, ack_o 0, err_o 0. stall_o is 0 after reset because no request is present.
- Memory array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If MemRead_i or MemWrite_i is 1, accept the request (cycle T).
  - On accept, latch op, addr_i and data_i, and load counter = LATENCY-1.
  - Next state is WAIT, or RESP if LATENCY=1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access on the latched values and go to RESP.
  - Request inputs are ignored in WAIT; latched values govern.
- RESP:
  - ack_o=1 and stall_o=0 for exactly this cycle, which is cycle T+LATENCY.
  - Next state is IDLE unconditionally.
  - Request inputs during RESP are ignored; they still belong to the completing instruction, and the pipeline advances at the end of RESP.
- stall_o is combinational: (IDEX-independent) 1 when (state==IDLE and (MemRead_i|MemWrite_i)) or state==WAIT. Otherwise 0.
- Stall length per access = LATENCY cycles. Back-to-back memory instructions see an IDLE accept on the cycle after RESP.
- Read: data_o <= mem[idx], updated at the transition into RESP, so it is valid during RESP. data_o holds until the next successful read.
- Write: mem[idx] <= latched data at the transition into RESP. data_o is unchanged.
- Error conditions are checked on latched values:
  - both MemRead and MemWrite set;
  - addr[1:0] != 0;
  - idx >= DEPTH_WORDS.
- On error:
  - No memory write occurs.
  - data_o <= 0.
  - err_o=1 in RESP; the handshake is otherwise normal.
- Reset while in WAIT or RESP:
  - Abort immediately to IDLE.
  - A pending write is not performed.
  - ack_o, err_o and data_o are cleared.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds output ports rd_cnt_o[31:0], wr_cnt_o[31:0] and stall_cnt_o[31:0].
  - rd_cnt_o and wr_cnt_o increment in the RESP cycle of each successful read or write.
  - stall_cnt_o increments each cycle stall_o=1.
  - All counters saturate at 32'hFFFF_FFFF and clear on rst_i.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Store then load, LATENCY=4:
  - Stimulus: MemWrite_i=1, addr_i=0x10, data_i=0xDEADBEEF held from T. Then, after ack, MemRead_i=1, addr_i=0x10.
  - Required: stall_o=1 for T..T+3, ack_o=1 at T+4 with err_o=0.
  - Required: the read ack arrives 4 cycles after its accept with data_o=0xDEADBEEF.
- Back-to-back loads of 0x0 and 0x4, both preloaded:
  - Required: second accept on the cycle after the first RESP.
  - Required: two ack pulses 5 cycles apart, correct data each time, no double access.
- Misaligned load, addr_i=0x13:
  - Required: ack_o=1 and err_o=1 at T+4, data_o=0, memory unchanged.
- Out-of-range store, addr_i=DEPTH_WORDS*4 with data_i=0x1:
  - Required: err_o=1 at ack.
  - Required: a subsequent read of 0x0 returns its prior value (no aliasing).
- Reset mid-write:
  - Stimulus: store 0xCAFEF00D to 0x20, assert rst_i at T+2 for 1 cycle.
  - Required: state IDLE and no ack.
  - Required: a later read of 0x20 returns the old value.
- LATENCY=1 plus the DMEM_PERF_CNT_EN build:
  - Stimulus: 3 reads and 2 writes.
  - Required: each ack one cycle after accept, stall pulse 1 cycle per access.
  - Required: rd_cnt_o=3, wr_cnt_o=2, stall_cnt_o=5.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline for LATENCY cycles per access.
// Optional performance counters are compiled in when DMEM_PERF_CNT_EN is defined.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no access in flight; a request level is accepted here
// WAIT  | counting down the access latency on latched operands
// RESP  | access complete: ack_o (and err_o) pulse, pipeline released
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        lat_rd, lat_wr;
  logic [31:0] lat_addr, lat_data;
  logic        req;
  logic        do_access;

  logic        acc_rd, acc_wr, acc_err;
  logic [31:0] acc_addr, acc_data;
  logic [29:0] acc_idx;
  logic [AW-1:0] mem_idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req = MemRead_i | MemWrite_i;

  // With LATENCY=1 the access happens on the accept edge, so the live inputs stand in for the latches.
  assign acc_rd   = (state == IDLE) ? MemRead_i  : lat_rd;
  assign acc_wr   = (state == IDLE) ? MemWrite_i : lat_wr;
  assign acc_addr = (state == IDLE) ? addr_i     : lat_addr;
  assign acc_data = (state == IDLE) ? data_i     : lat_data;
  assign acc_idx  = acc_addr[31:2];
  assign mem_idx  = acc_idx[AW-1:0];
  assign acc_err  = (acc_rd & acc_wr) | (acc_addr[1:0] != 2'b00) |
                    ({2'b00, acc_idx} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_o   = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall_o = 1'b1;
          cnt_nxt = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          cnt_nxt   = 8'd0;
          state_nxt = RESP;
          do_access = 1'b1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      data_o   <= 32'd0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_addr <= 32'd0;
      lat_data <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_o <= do_access;
      err_o <= do_access & acc_err;
      if (state == IDLE && req) begin
        lat_rd   <= MemRead_i;
        lat_wr   <= MemWrite_i;
        lat_addr <= addr_i;
        lat_data <= data_i;
      end
      if (do_access) begin
        if (acc_err)
          data_o <= 32'd0;
        else if (acc_rd)
          data_o <= mem[mem_idx];
      end
    end
  end

  // The array has no reset; a reset on the completing edge still suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_access && acc_wr && !acc_err)
      mem[mem_idx] <= acc_data;
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_o    <= 32'd0;
      wr_cnt_o    <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (state == RESP && lat_rd && !err_o && rd_cnt_o != 32'hFFFF_FFFF)
        rd_cnt_o <= rd_cnt_o + 32'd1;
      if (state == RESP && lat_wr && !err_o && wr_cnt_o != 32'hFFFF_FFFF)
        wr_cnt_o <= wr_cnt_o + 32'd1;
      if (stall_o && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=4 instance driven from a vector table, LATENCY=1 instance for short accesses.
`timescale 1ns/1ps

module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst4, rd4, wr4, stall4, ack4, err4;
  logic [31:0] addr4, wd4, rdata4;
  logic        rst1, rd1, wr1, stall1, ack1, err1;
  logic [31:0] addr1, wd1, rdata1;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rdc4, wrc4, stc4, rdc1, wrc1, stc1;
`endif

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .MemRead_i(rd4), .MemWrite_i(wr4),
    .addr_i(addr4), .data_i(wd4), .data_o(rdata4),
    .stall_o(stall4), .ack_o(ack4), .err_o(err4)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt_o(rdc4), .wr_cnt_o(wrc4), .stall_cnt_o(stc4)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .data_i(wd1), .data_o(rdata1),
    .stall_o(stall1), .ack_o(ack1), .err_o(err1)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt_o(rdc1), .wr_cnt_o(wrc1), .stall_cnt_o(stc1)
`endif
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          e_err;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
    end else begin
      rd4 = rd; wr4 = wr; addr4 = a; wd4 = d;
    end
  endtask

  function automatic logic g_ack(input bit sel);
    return sel ? ack1 : ack4;
  endfunction
  function automatic logic g_stall(input bit sel);
    return sel ? stall1 : stall4;
  endfunction
  function automatic logic g_err(input bit sel);
    return sel ? err1 : err4;
  endfunction
  function automatic logic [31:0] g_data(input bit sel);
    return sel ? rdata1 : rdata4;
  endfunction

  // Present a request from the next cycle and hold it until the ack; requests stay asserted on return.
  task automatic run_access(input bit sel, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input bit e_err, input logic [31:0] e_data,
                            input int lat, output int ack_cyc);
    exp_t x;
    bit   got;
    int   nstall;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    x.err = e_err; x.data = e_data;
    exp_q.push_back(x);
    got = 0; nstall = 0; ack_cyc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (g_ack(sel)) begin
        got = 1;
        ack_cyc = cyc;
        x = exp_q.pop_front();
        check("latency", 32'(k), 32'(lat));
        check("stall_cycles", 32'(nstall), 32'(lat));
        check("stall_at_ack", {31'd0, g_stall(sel)}, 32'd0);
        check("err", {31'd0, g_err(sel)}, {31'd0, x.err});
        check("data", g_data(sel), x.data);
      end else begin
        if (g_stall(sel)) nstall++;
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic go_idle(input bit sel);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("idle_stall", {31'd0, g_stall(sel)}, 32'd0);
    check("idle_ack", {31'd0, g_ack(sel)}, 32'd0);
  endtask

  vec_t vecs[12];
  int   acks[12];
  int   ac;
  bit   saw_ack;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h2222_2222};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h5555_5555, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

    rst4 = 1'b1; rst1 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("rst_data4", rdata4, 32'd0);
    check("rst_ack4", {31'd0, ack4}, 32'd0);
    check("rst_err4", {31'd0, err4}, 32'd0);
    check("rst_stall4", {31'd0, stall4}, 32'd0);
    check("rst_data1", rdata1, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_stall1", {31'd0, stall1}, 32'd0);

    // Back-to-back accesses straight from the table.
    for (int i = 0; i < 12; i++) begin
      run_access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                 vecs[i].e_err, vecs[i].e_data, 4, ac);
      acks[i] = ac;
    end
    check("b2b_ack_spacing", 32'(acks[5] - acks[4]), 32'd5);
    go_idle(1'b0);

    // Reset two cycles into a store must drop it.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_abort_stall", {31'd0, stall4}, 32'd0);
    check("rst_abort_data", rdata4, 32'd0);
    saw_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (ack4) saw_ack = 1'b1;
      @(negedge clk);
    end
    check("rst_abort_no_ack", {31'd0, saw_ack}, 32'd0);
    run_access(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'h0BAD_F00D, 4, ac);
    go_idle(1'b0);

    // LATENCY=1 instance: three reads, two writes.
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'hAAAA_0001, 1'b0, 32'h0000_0000, 1, ac);
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'hBBBB_0002, 1'b0, 32'h0000_0000, 1, ac);
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'hAAAA_0001, 1, ac);
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'd0, 1'b0, 32'hBBBB_0002, 1, ac);
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0, 32'hAAAA_0001, 1, ac);
    go_idle(1'b1);
    @(negedge clk);
`ifdef DMEM_PERF_CNT_EN
    check("rd_cnt", rdc1, 32'd3);
    check("wr_cnt", wrc1, 32'd2);
    check("stall_cnt", stc1, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
